// File: rtl/button_ctrl_pkg.sv
// Shared defaults and the width helper for the button_ctrl block.
package button_ctrl_pkg;

  localparam int DEF_NUM_BTN       = 4;
  localparam int DEF_DEB_CYCLES    = 16;
  localparam int DEF_NUM_MODES     = 3;
  localparam int DEF_SW_W          = 4;
  localparam int DEF_REPEAT_DELAY  = 1000;
  localparam int DEF_REPEAT_PERIOD = 250;

  // Smallest width w with 2**w >= value.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce counter, stable level,
// rise strobe and (with BUTTON_CTRL_REPEAT_EN defined) hold-to-repeat strobes.
module btn_debounce
  import button_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES
`ifdef BUTTON_CTRL_REPEAT_EN
  ,
  parameter bit REPEAT_ENABLE = 1'b0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic sysclk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = clog2(DEB_CYCLES);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             w_differ;
  logic             w_flip;
  logic             w_rise;
  logic             w_repeat;

  assign w_differ = r_sync[1] ^ r_level;
  assign w_flip   = w_differ && (r_cnt == CNT_W'(DEB_CYCLES - 1));
  assign w_rise   = w_flip && !r_level;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_cnt   <= (!w_differ || w_flip) ? '0 : r_cnt + CNT_W'(1);
      r_press <= w_rise || w_repeat;
      if (w_flip) r_level <= ~r_level;
    end
  end

`ifdef BUTTON_CTRL_REPEAT_EN
  if (REPEAT_ENABLE) begin : g_repeat
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;
    logic             w_rep_hit;

    // First repeat waits REPEAT_DELAY after the press strobe, later ones REPEAT_PERIOD.
    assign w_rep_hit = r_level && !w_flip &&
                       (r_rep_first ? (r_rep_cnt == REP_W'(REPEAT_DELAY - 1))
                                    : (r_rep_cnt == REP_W'(REPEAT_PERIOD - 1)));

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else if (w_rise) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end else if (!r_level || w_flip || w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= r_rep_cnt + REP_W'(1);
      end
    end

    assign w_repeat = w_rep_hit;
  end else begin : g_no_repeat
    assign w_repeat = 1'b0;
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_ctrl.sv
// Debounced push-button front end with a mode selector on the change button.
// Optional hold-to-repeat strobes are built when BUTTON_CTRL_REPEAT_EN is defined.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int NUM_BTN       = DEF_NUM_BTN,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int NUM_MODES     = DEF_NUM_MODES,
  parameter int SW_W          = DEF_SW_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  localparam int MODE_W       = clog2(NUM_MODES)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               change,
  input  logic [SW_W-1:0]    sw,
  output logic [MODE_W-1:0]  mode_idx,
  output logic               mode_pulse,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [SW_W-1:0]    sw_sync
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic               w_change_press;
  logic               w_unused_change_level;
  logic [MODE_W-1:0]  r_mode;
  logic [MODE_W-1:0]  w_mode_next;
  logic [SW_W-1:0]    r_sw_meta;
  logic [SW_W-1:0]    r_sw_sync;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES)
`ifdef BUTTON_CTRL_REPEAT_EN
      ,
      .REPEAT_ENABLE(1'b1),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_btn (
      .sysclk (sysclk),
      .reset  (reset),
      .i_raw  (btn[i]),
      .o_level(w_level[i]),
      .o_press(w_press[i])
    );
  end

  // The change button never auto-repeats: holding it advances the mode once.
  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_change (
    .sysclk (sysclk),
    .reset  (reset),
    .i_raw  (change),
    .o_level(w_unused_change_level),
    .o_press(w_change_press)
  );

  assign w_mode_next = (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + MODE_W'(1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_mode    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (w_change_press) r_mode <= w_mode_next;
    end
  end

  // The strobe cycle already shows the new mode; r_mode catches up on the next edge.
  assign mode_idx   = w_change_press ? w_mode_next : r_mode;
  assign mode_pulse = w_change_press;
  assign btn_level  = w_level;
  assign btn_press  = w_press & ~{NUM_BTN{w_change_press}};
  assign sw_sync    = r_sw_sync;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: sliding-window behavioural model compared
// every cycle, plus directed literal checks. Honours BUTTON_CTRL_REPEAT_EN.
module tb_button_ctrl;

  localparam int NUM_BTN       = 4;
  localparam int DEB_CYCLES    = 16;
  localparam int NUM_MODES     = 3;
  localparam int SW_W          = 4;
  localparam int REPEAT_DELAY  = 100;
  localparam int REPEAT_PERIOD = 20;
  localparam int MODE_W        = 2;
  localparam int NCH           = NUM_BTN + 1;
  localparam int H             = DEB_CYCLES + 2;

  logic               sysclk = 1'b0;
  logic               reset;
  logic [NUM_BTN-1:0] btn;
  logic               change;
  logic [SW_W-1:0]    sw;
  logic [MODE_W-1:0]  mode_idx;
  logic               mode_pulse;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [SW_W-1:0]    sw_sync;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulse_cnt = 0;

  button_ctrl #(
    .NUM_BTN      (NUM_BTN),
    .DEB_CYCLES   (DEB_CYCLES),
    .NUM_MODES    (NUM_MODES),
    .SW_W         (SW_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .btn       (btn),
    .change    (change),
    .sw        (sw),
    .mode_idx  (mode_idx),
    .mode_pulse(mode_pulse),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .sw_sync   (sw_sync)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Model: a level flips once the last DEB_CYCLES synchronised samples all disagree
  // with it; synchronised sample at edge n is the raw value taken at edge n-2.
  bit [H-1:0]        hist [NCH];
  bit                m_level [NCH];
  int                m_held [NCH];
  bit                m_rise [NCH];
  bit                m_rep [NCH];
  int                m_mode = 0;
  bit                m_pulse = 1'b0;
  bit [NUM_BTN-1:0]  m_press = '0;
  bit [SW_W-1:0]     m_sw1 = '0;
  bit [SW_W-1:0]     m_sw2 = '0;

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c] = '0; m_level[c] = 1'b0; m_held[c] = 0; m_rise[c] = 1'b0; m_rep[c] = 1'b0;
      end
      m_mode = 0; m_pulse = 1'b0; m_press = '0; m_sw1 = '0; m_sw2 = '0;
      cyc = 0;
    end else begin
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        bit raw;
        bit [DEB_CYCLES-1:0] win;
        raw = (c == NUM_BTN) ? change : btn[c];
        hist[c] = {hist[c][H-2:0], raw};
        win = hist[c][H-1:2];
        m_rise[c] = 1'b0;
        m_rep[c]  = 1'b0;
        if (m_level[c] ? (win == '0) : (win == '1)) begin
          m_level[c] = !m_level[c];
          m_rise[c]  = m_level[c];
          m_held[c]  = 0;
        end else if (m_level[c]) begin
          m_held[c]++;
        end
`ifdef BUTTON_CTRL_REPEAT_EN
        if (c < NUM_BTN && m_level[c] && !m_rise[c] && m_held[c] >= REPEAT_DELAY &&
            ((m_held[c] - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
          m_rep[c] = 1'b1;
`endif
      end
      m_pulse = m_rise[NUM_BTN];
      if (m_pulse) m_mode = (m_mode + 1) % NUM_MODES;
      for (int i = 0; i < NUM_BTN; i++) m_press[i] = (m_rise[i] | m_rep[i]) & !m_pulse;
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge sysclk) begin
    bit [NUM_BTN-1:0] lv;
    for (int i = 0; i < NUM_BTN; i++) lv[i] = m_level[i];
    check("model_btn_level", 32'(btn_level), 32'(lv));
    check("model_btn_press", 32'(btn_press), 32'(m_press));
    check("model_mode_idx", 32'(mode_idx), 32'(m_mode));
    check("model_mode_pulse", 32'(mode_pulse), 32'(m_pulse));
    check("model_sw_sync", 32'(sw_sync), 32'(m_sw2));
    if (mode_pulse === 1'b1) pulse_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int rep_q[$];
    int exp_rep[$];

    reset = 1'b1; btn = '0; change = 1'b0; sw = '0;
    tick(3);
    check("reset_btn_level", 32'(btn_level), 0);
    check("reset_btn_press", 32'(btn_press), 0);
    check("reset_mode_idx", 32'(mode_idx), 0);
    check("reset_mode_pulse", 32'(mode_pulse), 0);
    check("reset_sw_sync", 32'(sw_sync), 0);
    reset = 1'b0;

    // btn[0] rises at edge 10 -> level and single strobe at edge 28
    tick(10);
    btn[0] = 1'b1;
    tick(17);
    check("deb_level_e27", 32'(btn_level[0]), 0);
    tick(1);
    check("deb_level_e28", 32'(btn_level[0]), 1);
    check("deb_press_e28", 32'(btn_press[0]), 1);
    tick(1);
    check("deb_press_e29", 32'(btn_press[0]), 0);
    check("deb_level_e29", 32'(btn_level[0]), 1);

    // 5-cycle glitches never reach the stable level
    for (int p = 0; p < 10; p++) begin
      btn[1] = 1'b1; tick(5);
      btn[1] = 1'b0; tick(5);
    end
    tick(20);
    check("glitch_level1", 32'(btn_level[1]), 0);

    // Three change presses; the last one held long to show a single advance
    p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      change = 1'b1;
      tick(18);
      check("mode_pulse_on_accept", 32'(mode_pulse), 1);
      check("mode_idx_on_accept", 32'(mode_idx), 32'((k + 1) % 3));
      tick((k == 2) ? 60 : 20);
      change = 1'b0;
      tick(20);
    end
    check("mode_pulse_count", 32'(pulse_cnt - p0), 3);
    check("mode_idx_wrapped", 32'(mode_idx), 0);

    // change and btn[2] accepted on the same edge: press dropped, level kept
    change = 1'b1; btn[2] = 1'b1;
    tick(18);
    check("same_edge_pulse", 32'(mode_pulse), 1);
    check("same_edge_press2", 32'(btn_press[2]), 0);
    check("same_edge_level2", 32'(btn_level[2]), 1);
    check("same_edge_mode", 32'(mode_idx), 1);
    tick(1);
    check("same_edge_press2_after", 32'(btn_press[2]), 0);
    change = 1'b0; btn[2] = 1'b0; btn[0] = 1'b0;
    tick(20);

    // Switch synchroniser: two-edge latency
    sw = 4'b1010;
    tick(1);
    check("sw_sync_1edge", 32'(sw_sync), 0);
    tick(1);
    check("sw_sync_2edge", 32'(sw_sync), 32'hA);

    // Two channels accepted together each strobe
    btn[1] = 1'b1; btn[3] = 1'b1;
    tick(18);
    check("multi_press", 32'(btn_press), 32'b1010);
    tick(1);
    check("multi_press_after", 32'(btn_press), 0);
    btn = '0;
    tick(20);

    // Reset in the middle of a debounce (counter at 10)
    check("pre_reset_mode", 32'(mode_idx), 1);
    btn[0] = 1'b1;
    tick(12);
    #1 reset = 1'b1;
    #1;
    check("midreset_btn_level", 32'(btn_level), 0);
    check("midreset_btn_press", 32'(btn_press), 0);
    check("midreset_mode_idx", 32'(mode_idx), 0);
    check("midreset_mode_pulse", 32'(mode_pulse), 0);
    check("midreset_sw_sync", 32'(sw_sync), 0);
    tick(2);
    reset = 1'b0;
    tick(17);
    check("post_reset_press_e17", 32'(btn_press[0]), 0);
    check("post_reset_level_e17", 32'(btn_level[0]), 0);
    tick(1);
    check("post_reset_press_e18", 32'(btn_press[0]), 1);
    check("post_reset_level_e18", 32'(btn_level[0]), 1);
    btn[0] = 1'b0;
    tick(20);

    // Long hold on btn[3]: strobe offsets relative to acceptance
    btn[3] = 1'b1;
    tick(18);
    for (int j = 0; j < 200; j++) begin
      if (btn_press[3] === 1'b1) rep_q.push_back(j);
      tick(1);
    end
`ifdef BUTTON_CTRL_REPEAT_EN
    exp_rep = '{0, 100, 120, 140, 160, 180};
`else
    exp_rep = '{0};
`endif
    check("hold_strobe_count", 32'(rep_q.size()), 32'(exp_rep.size()));
    for (int j = 0; j < exp_rep.size() && j < rep_q.size(); j++)
      check("hold_strobe_offset", 32'(rep_q[j]), 32'(exp_rep[j]));
    btn[3] = 1'b0;
    tick(25);
    check("release_level3", 32'(btn_level[3]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
